seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 141 ++++++++++++++
 tb/tb_seg7_scan.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - eight-digit multiplexed seven-segment scanner with shadow registers
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (auto-blank leading zero digits)
module seg7_scan #(
   parameter int DIV_CNT = 100000,
   parameter int GAP_CNT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_i,
   input  logic        load_i,
   input  logic [7:0]  dp_i,
   input  logic [7:0]  blank_i,
   output logic [7:0]  disp_an_o,
   output logic [7:0]  disp_seg_o
);

   // One counter serves both states, so it must reach the larger of the two limits.
   localparam int MAX_CNT = (DIV_CNT > GAP_CNT) ? DIV_CNT : GAP_CNT;
   localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CNT - 1);
   localparam logic [CW-1:0] GAP_LAST = (GAP_CNT > 0) ? CW'(GAP_CNT - 1) : '0;

   typedef enum logic {SHOW, GAP} state_t;

   state_t        state;
   logic [2:0]    idx;
   logic [CW-1:0] cnt;
   logic [31:0]   data_sh;
   logic [7:0]    dp_sh;
   logic [7:0]    blank_sh;

   logic [2:0]    nxt_idx;
   logic [3:0]    nxt_nib;
   logic          nxt_dark;
   logic [7:0]    nxt_an;
   logic [7:0]    nxt_seg;

   // Active-low segment pattern g..a for one hex nibble.
   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [2:0] lz_hi;

   // Highest nonzero shadow nibble; digit 0 is the floor so all-zero data still shows "0".
   always_comb begin
      lz_hi = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (data_sh[4*k +: 4] != 4'h0) lz_hi = 3'(k);
      end
   end
`endif

   // Anode/segment value for the digit the next slot will show, taken from the shadow registers.
   always_comb begin
      nxt_idx  = idx + 3'd1;
      nxt_nib  = data_sh[{nxt_idx, 2'b00} +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      nxt_dark = blank_sh[nxt_idx] | (nxt_idx > lz_hi);
`else
      nxt_dark = blank_sh[nxt_idx];
`endif
      if (nxt_dark) begin
         nxt_an  = 8'hFF;
         nxt_seg = 8'hFF;
      end else begin
         nxt_an  = ~(8'b1 << nxt_idx);
         nxt_seg = {~dp_sh[nxt_idx], hex_glyph(nxt_nib)};
      end
   end

   // Scan FSM with shadow capture; outputs change on the same edge as state/idx.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= GAP;
         idx        <= 3'd7;
         cnt        <= '0;
         data_sh    <= '0;
         dp_sh      <= '0;
         blank_sh   <= '0;
         disp_an_o  <= 8'hFF;
         disp_seg_o <= 8'hFF;
      end else begin
         if (load_i) begin
            data_sh  <= data_i;
            dp_sh    <= dp_i;
            blank_sh <= blank_i;
         end
         case (state)
            SHOW: begin
               if (cnt == DIV_LAST) begin
                  cnt <= '0;
                  if (GAP_CNT == 0) begin
                     idx        <= nxt_idx;
                     disp_an_o  <= nxt_an;
                     disp_seg_o <= nxt_seg;
                  end else begin
                     state      <= GAP;
                     disp_an_o  <= 8'hFF;
                     disp_seg_o <= 8'hFF;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (GAP_CNT == 0 || cnt == GAP_LAST) begin
                  state      <= SHOW;
                  idx        <= nxt_idx;
                  cnt        <= '0;
                  disp_an_o  <= nxt_an;
                  disp_seg_o <= nxt_seg;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan (gap and no-gap builds side by side)
module tb_seg7_scan;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data;
   logic        load;
   logic [7:0]  dp;
   logic [7:0]  blank;
   logic [7:0]  an_a, seg_a, an_b, seg_b;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   seg7_scan #(.DIV_CNT(4), .GAP_CNT(2)) dut_a (
      .clk(clk), .rst(rst), .data_i(data), .load_i(load), .dp_i(dp), .blank_i(blank),
      .disp_an_o(an_a), .disp_seg_o(seg_a));

   seg7_scan #(.DIV_CNT(4), .GAP_CNT(0)) dut_b (
      .clk(clk), .rst(rst), .data_i(data), .load_i(load), .dp_i(dp), .blank_i(blank),
      .disp_an_o(an_b), .disp_seg_o(seg_b));

   // Reference model: timeline position derived arithmetically from edges since reset.
   logic [31:0] m_data;
   logic [7:0]  m_dp, m_blank;
   int          m_n;
   logic [7:0]  m_lat_an [2];
   logic [7:0]  m_lat_seg[2];
   logic [7:0]  m_an [2];
   logic [7:0]  m_seg[2];

   function automatic int gap_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   // Reset leaves the block in a gap that lasts at least one cycle.
   function automatic int lead_of(input int k);
      return (gap_of(k) == 0) ? 1 : gap_of(k);
   endfunction

   function automatic logic [7:0] glyph(input logic [3:0] v);
      logic [7:0] t [16];
      t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return t[v];
   endfunction

   function automatic void digit_view(input logic [31:0] d, input logic [7:0] p,
                                      input logic [7:0] b, input int dig,
                                      output logic [7:0] an, output logic [7:0] seg);
      bit dark;
      logic [3:0] nib;
      logic [7:0] g;
      dark = b[dig];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      begin
         int hi;
         hi = 0;
         for (int k = 1; k < 8; k++) if (((d >> (4 * k)) & 32'hF) != 0) hi = k;
         if (dig > hi) dark = 1'b1;
      end
`endif
      nib = 4'((d >> (4 * dig)) & 32'hF);
      g   = glyph(nib);
      if (dark) begin
         an  = 8'hFF;
         seg = 8'hFF;
      end else begin
         an  = 8'hFF ^ (8'd1 << dig);
         seg = {~p[dig], g[6:0]};
      end
   endfunction

   // Model step at each rising edge.
   always @(posedge clk) begin
      int u, per, off, dig;
      logic [7:0] ta, ts;
      if (rst) begin
         m_n = 0;
         m_data = '0; m_dp = '0; m_blank = '0;
         for (int k = 0; k < 2; k++) begin
            m_an[k] = 8'hFF;
            m_seg[k] = 8'hFF;
         end
      end else begin
         m_n++;
         for (int k = 0; k < 2; k++) begin
            u = m_n - lead_of(k);
            if (u < 0) begin
               m_an[k] = 8'hFF;
               m_seg[k] = 8'hFF;
            end else begin
               per = D + gap_of(k);
               off = u % per;
               dig = (u / per) % 8;
               if (off == 0) begin
                  digit_view(m_data, m_dp, m_blank, dig, ta, ts);
                  m_lat_an[k] = ta;
                  m_lat_seg[k] = ts;
               end
               if (off < D) begin
                  m_an[k] = m_lat_an[k];
                  m_seg[k] = m_lat_seg[k];
               end else begin
                  m_an[k] = 8'hFF;
                  m_seg[k] = 8'hFF;
               end
            end
         end
         if (load) begin
            m_data = data; m_dp = dp; m_blank = blank;
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if (an_a !== m_an[0] || seg_a !== m_seg[0]) begin
            miscompares++;
            $display("FAIL scan_gap t=%0t an=%h seg=%h expected an=%h seg=%h",
                     $time, an_a, seg_a, m_an[0], m_seg[0]);
         end
         vectors++;
         if (an_b !== m_an[1] || seg_b !== m_seg[1]) begin
            miscompares++;
            $display("FAIL scan_nogap t=%0t an=%h seg=%h expected an=%h seg=%h",
                     $time, an_b, seg_b, m_an[1], m_seg[1]);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [7:0] an_act, input logic [7:0] seg_act,
                        input logic [7:0] an_exp, input logic [7:0] seg_exp);
      vectors++;
      if (an_act !== an_exp || seg_act !== seg_exp) begin
         miscompares++;
         $display("FAIL %s an=%h seg=%h expected an=%h seg=%h", name, an_act, seg_act, an_exp, seg_exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
      data = d; dp = p; blank = b; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   // Advance to the first cycle of the next gap-build slot for digit dig.
   task automatic wait_slot(input int dig);
      int u;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         u = m_n - 2;
         if (u >= 0 && (u % 6) == 0 && ((u / 6) % 8) == dig) found = 1'b1;
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_slot digit %0d not reached within 200 cycles", dig);
      end
   endtask

   typedef struct {
      logic [31:0] d;
      logic [7:0]  p;
      logic [7:0]  b;
      int          dig;
      logic [7:0]  an;
      logic [7:0]  seg;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int c, ffs;
      bit seen_off;
      logic [7:0] prev;

      tbl[0] = '{32'h89ABCDEF, 8'h00, 8'h00, 0, 8'hFE, 8'h8E};
      tbl[1] = '{32'h89ABCDEF, 8'h00, 8'h00, 1, 8'hFD, 8'h86};
      tbl[2] = '{32'h00000000, 8'h01, 8'h04, 0, 8'hFE, 8'h40};
      tbl[3] = '{32'h00000000, 8'h01, 8'h04, 2, 8'hFF, 8'hFF};
      tbl[4] = '{32'h76543210, 8'h80, 8'h00, 7, 8'h7F, 8'h78};
      tbl[5] = '{32'h76543210, 8'h00, 8'h00, 3, 8'hF7, 8'hB0};
      tbl[6] = '{32'h00000A00, 8'h00, 8'h00, 2, 8'hFB, 8'h88};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      tbl[7] = '{32'h00000A00, 8'h00, 8'h00, 3, 8'hFF, 8'hFF};
`else
      tbl[7] = '{32'h00000A00, 8'h00, 8'h00, 3, 8'hF7, 8'hC0};
`endif
      tbl[8] = '{32'h12345678, 8'hFF, 8'hFE, 0, 8'hFE, 8'h00};

      rst = 1'b1; load = 1'b0; data = '0; dp = '0; blank = '0;
      tick();
      tick();
      check("reset_gap", an_a, seg_a, 8'hFF, 8'hFF);
      check("reset_nogap", an_b, seg_b, 8'hFF, 8'hFF);
      chk_en = 1'b1;
      rst = 1'b0;

      // Table-driven glyph/anode checks.
      for (int i = 0; i < 9; i++) begin
         do_load(tbl[i].d, tbl[i].p, tbl[i].b);
         wait_slot(tbl[i].dig);
         check($sformatf("tbl%0d", i), an_a, seg_a, tbl[i].an, tbl[i].seg);
      end

      // Full scan period between consecutive digit-0 slots.
      do_load(32'h89ABCDEF, 8'h00, 8'h00);
      wait_slot(0);
      c = 0; seen_off = 1'b0;
      while (c < 100 && !(seen_off && an_a == 8'hFE)) begin
         tick();
         c++;
         if (an_a != 8'hFE) seen_off = 1'b1;
      end
      check_int("scan_period", c, 48);

      // Mid-slot load keeps the current glyph and shows up on the next digit-0 slot.
      wait_slot(0);
      tick();
      do_load(32'h00000001, 8'h00, 8'h00);
      check("mid_load_hold", an_a, seg_a, 8'hFE, 8'h8E);
      tick();
      check("mid_load_hold_end", an_a, seg_a, 8'hFE, 8'h8E);
      wait_slot(0);
      check("mid_load_next", an_a, seg_a, 8'hFE, 8'hF9);

      // Back-to-back loads: last one wins.
      data = 32'h11111111; load = 1'b1; tick();
      data = 32'h22222222; tick();
      load = 1'b0;
      wait_slot(0);
      check("b2b_last_wins", an_a, seg_a, 8'hFE, 8'hA4);

      // No-gap build never blanks all anodes and wraps 7 -> 0 on consecutive cycles.
      do_load(32'h89ABCDEF, 8'h00, 8'h00);
      ffs = 0;
      prev = an_b;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (an_b == 8'hFF) ffs++;
         if (prev == 8'h7F && an_b != 8'h7F) check("nogap_wrap", an_b, seg_b, 8'hFE, 8'h8E);
         prev = an_b;
      end
      check_int("nogap_no_ff", ffs, 0);

      // Reset mid-slot of digit 5, with a load that must be ignored.
      wait_slot(5);
      tick();
      rst = 1'b1; load = 1'b1; data = 32'hFFFFFFFF;
      tick();
      check("rst_abort", an_a, seg_a, 8'hFF, 8'hFF);
      rst = 1'b0; load = 1'b0;
      tick();
      check("rst_gap", an_a, seg_a, 8'hFF, 8'hFF);
      tick();
      check("rst_resume_d0", an_a, seg_a, 8'hFE, 8'hC0);

      // Randomized loads and occasional resets, checked every cycle by the model.
      for (int i = 0; i < 3000; i++) begin
         load = 1'b0;
         rst = 1'b0;
         if ($urandom_range(0, 9) == 0) begin
            data  = $urandom >> $urandom_range(0, 31);
            dp    = 8'($urandom);
            blank = 8'($urandom & $urandom);
            load  = 1'b1;
         end
         if ($urandom_range(0, 299) == 0) rst = 1'b1;
         tick();
      end
      load = 1'b0;
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
